// File: rtl/conv_stream_core_if.sv
// Pixel-in / result-out stream bundle for conv_stream_core.
// The core is the slave; the upstream reader and the result collector form the master side.
interface conv_stream_core_if #(
    parameter int WORD_LENGTH = 8,
    parameter int ACC_LENGTH  = 16
);
    logic                   in_valid;
    logic [WORD_LENGTH-1:0] data_in;
    logic                   in_ready;
    logic [ACC_LENGTH-1:0]  data_out;
    logic                   out_valid;
    logic                   out_last;

    modport master (
        output in_valid, data_in,
        input  in_ready, data_out, out_valid, out_last
    );

    modport slave (
        input  in_valid, data_in,
        output in_ready, data_out, out_valid, out_last
    );
endinterface

// File: rtl/conv_stream_core.sv
// Streaming KxK convolution with stride, runtime bias and saturation; result 2 edges after the window-completing accept.
// Input flow control is valid/ready (bubbles tolerated); results have no backpressure and are emitted one per valid cycle.
module conv_stream_core #(
    parameter int WORD_LENGTH = 8,
    parameter int ACC_LENGTH  = 16,
    parameter int IMAGE_SIZE  = 36,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WORD_LENGTH-1:0] weight_value,
    input  logic [ACC_LENGTH-1:0]                       bias,
    conv_stream_core_if.slave                           strm,
    output logic                                        sat_flag,
    output logic                                        busy,
    output logic                                        frame_done
);
    localparam int W     = WORD_LENGTH;
    localparam int K     = KERNEL_SIZE;
    localparam int IS    = IMAGE_SIZE;
    localparam int SUMW  = 2*W + $clog2(K*K) + 1;
    localparam int SRLEN = (K-1)*IS + K;
    localparam int CW    = $clog2(IS);
    localparam int OUTN  = (IS - K) / STRIDE + 1;
    localparam int LASTP = (K - 1) + (OUTN - 1) * STRIDE;

    localparam logic signed [SUMW-1:0] MAXV = {{(SUMW-ACC_LENGTH+1){1'b0}}, {(ACC_LENGTH-1){1'b1}}};
    localparam logic signed [SUMW-1:0] MINV = {{(SUMW-ACC_LENGTH+1){1'b1}}, {(ACC_LENGTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [CW-1:0]            row_q, col_q;
    logic                     drain_q;
    logic                     in_ready_q, busy_q, frame_done_q;
    logic [K*K*W-1:0]         wt_q;
    logic [ACC_LENGTH-1:0]    bias_q;

    logic signed [W-1:0]      sr_q [SRLEN];
    logic                     win_vld_q, win_last_q;
    logic                     s1_vld_q, s1_last_q;
    logic signed [SUMW-1:0]   s1_sum_q;
    logic                     out_vld_q, out_last_q, sat_q;
    logic [ACC_LENGTH-1:0]    out_dat_q;

    logic                     accept, win_hit, at_last, clamp_d;
    logic signed [SUMW-1:0]   acc_d;
    logic [ACC_LENGTH-1:0]    sat_dat_d;

    assign accept = strm.in_valid & in_ready_q;

    // Position of the pixel being accepted decides whether it completes a strided window.
    assign win_hit = (row_q >= CW'(K-1)) && (col_q >= CW'(K-1)) &&
                     (((int'(row_q) - (K-1)) % STRIDE) == 0) &&
                     (((int'(col_q) - (K-1)) % STRIDE) == 0);
    assign at_last = (row_q == CW'(LASTP)) && (col_q == CW'(LASTP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            drain_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wt_q         <= '0;
            bias_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        wt_q       <= weight_value;
                        bias_q     <= bias;
                        row_q      <= '0;
                        col_q      <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col_q == CW'(IS-1)) begin
                            col_q <= '0;
                            if (row_q == CW'(IS-1)) begin
                                state_q    <= DRAIN;
                                in_ready_q <= 1'b0;
                                drain_q    <= 1'b0;
                            end else begin
                                row_q <= row_q + CW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= DONE;
                end
                DONE: begin
                    // frame_done lands one cycle after DONE so it can never share a cycle with out_last.
                    state_q      <= IDLE;
                    frame_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Window (i,j) = pixel (r-K+1+i, c-K+1+j) sits at delay (K-1-i)*IS + (K-1-j) in the shift chain.
    always_comb begin
        acc_d = SUMW'($signed(bias_q));
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                acc_d = acc_d + SUMW'(sr_q[(K-1-i)*IS + (K-1-j)]) *
                                SUMW'($signed(wt_q[(i*K+j)*W +: W]));
            end
        end
    end

    always_comb begin
        clamp_d   = 1'b0;
        sat_dat_d = s1_sum_q[ACC_LENGTH-1:0];
        if (s1_sum_q > MAXV) begin
            clamp_d   = 1'b1;
            sat_dat_d = MAXV[ACC_LENGTH-1:0];
        end else if (s1_sum_q < MINV) begin
            clamp_d   = 1'b1;
            sat_dat_d = MINV[ACC_LENGTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SRLEN; k++) sr_q[k] <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (accept) begin
                sr_q[0] <= $signed(strm.data_in);
                for (int k = 1; k < SRLEN; k++) sr_q[k] <= sr_q[k-1];
            end
            win_vld_q  <= accept & win_hit;
            win_last_q <= accept & win_hit & at_last;
            s1_vld_q   <= win_vld_q;
            s1_last_q  <= win_last_q;
            if (win_vld_q) s1_sum_q <= acc_d;
            out_vld_q  <= s1_vld_q;
            out_last_q <= s1_last_q;
            if (s1_vld_q) out_dat_q <= sat_dat_d;
            if (start && state_q == IDLE) sat_q <= 1'b0;
            else if (s1_vld_q && clamp_d) sat_q <= 1'b1;
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.data_out  = out_dat_q;
    assign strm.out_valid = out_vld_q;
    assign strm.out_last  = out_last_q;
    assign sat_flag       = sat_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_conv_stream_core.sv
// Scoreboard bench: a stride-1 and a stride-2 core share one pixel stream; expectations come from a direct convolution model.
module tb_conv_stream_core;
    localparam int W   = 8;
    localparam int ACC = 16;
    localparam int IS  = 36;
    localparam int K   = 5;
    localparam int OA  = (IS - K) / 1 + 1;
    localparam int OB  = (IS - K) / 2 + 1;
    localparam int MAXV = (1 << (ACC-1)) - 1;
    localparam int MINV = -(1 << (ACC-1));

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [K*K*W-1:0]   wv = '0;
    logic [ACC-1:0]     bias_v = '0;
    logic               in_valid = 1'b0;
    logic [W-1:0]       din = '0;
    logic               sat_a, busy_a, fd_a, sat_b, busy_b, fd_b;

    conv_stream_core_if #(.WORD_LENGTH(W), .ACC_LENGTH(ACC)) ifa ();
    conv_stream_core_if #(.WORD_LENGTH(W), .ACC_LENGTH(ACC)) ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.data_in  = din;
    assign ifb.in_valid = in_valid;
    assign ifb.data_in  = din;

    conv_stream_core #(.WORD_LENGTH(W), .ACC_LENGTH(ACC), .IMAGE_SIZE(IS),
                       .KERNEL_SIZE(K), .STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .weight_value(wv), .bias(bias_v),
        .strm(ifa), .sat_flag(sat_a), .busy(busy_a), .frame_done(fd_a));

    conv_stream_core #(.WORD_LENGTH(W), .ACC_LENGTH(ACC), .IMAGE_SIZE(IS),
                       .KERNEL_SIZE(K), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .weight_value(wv), .bias(bias_v),
        .strm(ifb), .sat_flag(sat_b), .busy(busy_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    typedef struct {
        int     val;
        longint cyc;
        bit     last;
    } exp_t;

    exp_t   q [2][$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     out_cnt [2];
    int     push_cnt [2];
    int     done_cnt [2];
    bit     last_seen [2];
    bit     sat_exp [2];
    longint last_dat [2];
    int     img [IS*IS];
    int     wt [K*K];
    int     bias_i;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // A reset edge discards everything still in flight inside the cores.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            for (int id = 0; id < 2; id++) begin
                q[id].delete();
                last_dat[id] = 0;
            end
        end
    end

    task automatic mon(input int id, input logic ov, input logic ol,
                       input logic [ACC-1:0] dat, input logic fd);
        exp_t e;
        if (fd) begin
            chk("done_after_last", longint'(last_seen[id]), 1);
            done_cnt[id]++;
        end
        if (ov) begin
            chk("out_expected", longint'(q[id].size() != 0), 1);
            if (q[id].size() != 0) begin
                e = q[id].pop_front();
                chk("data", $signed(dat), e.val);
                chk("latency", cyc, e.cyc);
                chk("out_last", longint'(ol), longint'(e.last));
            end
            out_cnt[id]++;
            if (ol) last_seen[id] = 1'b1;
            last_dat[id] = $signed(dat);
        end else begin
            chk("data_hold", $signed(dat), last_dat[id]);
            chk("last_wo_valid", longint'(ol), 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.out_valid, ifa.out_last, ifa.data_out, fd_a);
        mon(1, ifb.out_valid, ifb.out_last, ifb.data_out, fd_b);
    end

    task automatic push_exp(input int id, input int s, input int o, input int r, input int c);
        exp_t e;
        int   sum;
        if (r >= K-1 && c >= K-1 && (r-K+1) % s == 0 && (c-K+1) % s == 0) begin
            sum = bias_i;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    sum += img[(r-K+1+i)*IS + (c-K+1+j)] * wt[i*K+j];
            if (sum > MAXV) begin sum = MAXV; sat_exp[id] = 1'b1; end
            else if (sum < MINV) begin sum = MINV; sat_exp[id] = 1'b1; end
            push_cnt[id]++;
            e.val  = sum;
            e.cyc  = cyc + 3;
            e.last = (push_cnt[id] == o*o);
            q[id].push_back(e);
        end
    endtask

    task automatic chk_rst();
        chk("rst_busy_a", longint'(busy_a), 0);
        chk("rst_busy_b", longint'(busy_b), 0);
        chk("rst_ovld_a", longint'(ifa.out_valid), 0);
        chk("rst_ovld_b", longint'(ifb.out_valid), 0);
        chk("rst_dout_a", longint'(ifa.data_out), 0);
        chk("rst_dout_b", longint'(ifb.data_out), 0);
        chk("rst_rdy_a", longint'(ifa.in_ready), 0);
        chk("rst_rdy_b", longint'(ifb.in_ready), 0);
        chk("rst_sat_a", longint'(sat_a), 0);
        chk("rst_done_a", longint'(fd_a), 0);
    endtask

    // mode 0: ones/bias 14, 1: r+c with centre tap, 2: +127 saturate, 3: -128 saturate
    task automatic run_frame(input int mode, input bit bubbles, input int abort_at, input int restart_at);
        int idx = 0;
        int budget = 0;
        int d0, d1;
        bit v;
        for (int p = 0; p < IS*IS; p++) begin
            case (mode)
                0: img[p] = 1;
                1: img[p] = p / IS + p % IS;
                2: img[p] = 127;
                default: img[p] = -128;
            endcase
        end
        for (int i = 0; i < K*K; i++) begin
            case (mode)
                0: wt[i] = 1;
                1: wt[i] = (i == (K/2)*K + K/2) ? 1 : 0;
                default: wt[i] = 127;
            endcase
        end
        bias_i = (mode == 0) ? 14 : 0;
        for (int id = 0; id < 2; id++) begin
            out_cnt[id]   = 0;
            push_cnt[id]  = 0;
            sat_exp[id]   = 1'b0;
            last_seen[id] = 1'b0;
        end
        d0 = done_cnt[0];
        d1 = done_cnt[1];

        @(negedge clk);
        for (int i = 0; i < K*K; i++) wv[i*W +: W] = W'(wt[i]);
        bias_v   = ACC'(bias_i);
        start    = 1'b1;
        in_valid = 1'b1;
        din      = W'(img[0]);
        chk("rdy_idle_start", longint'(ifa.in_ready), 0);

        while (idx < IS*IS && budget < 8000) begin
            @(negedge clk);
            budget++;
            start = (idx == restart_at);
            if (start) begin
                for (int i = 0; i < K*K; i++) wv[i*W +: W] = W'(3);
                bias_v = ACC'(100);
            end
            if (idx == abort_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_rst();
                repeat (5) @(negedge clk);
                chk("abort_busy", longint'(busy_a), 0);
                return;
            end
            v = bubbles ? ($urandom_range(0, 99) >= 30) : 1'b1;
            in_valid = v;
            din      = W'(img[idx]);
            if (v && ifa.in_ready) begin
                push_exp(0, 1, OA, idx / IS, idx % IS);
                push_exp(1, 2, OB, idx / IS, idx % IS);
                idx++;
            end
        end
        chk("frame_accepts", idx, IS*IS);

        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk("rdy_drain", longint'(ifa.in_ready), 0);
        chk("busy_drain", longint'(busy_a), 1);

        budget = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        chk("done_once_a", done_cnt[0], d0 + 1);
        chk("done_once_b", done_cnt[1], d1 + 1);
        chk("count_a", out_cnt[0], OA*OA);
        chk("count_b", out_cnt[1], OB*OB);
        chk("pending_a", q[0].size(), 0);
        chk("pending_b", q[1].size(), 0);
        chk("sat_a", longint'(sat_a), longint'(sat_exp[0]));
        chk("sat_b", longint'(sat_b), longint'(sat_exp[1]));
        chk("idle_busy_a", longint'(busy_a), 0);
        chk("idle_busy_b", longint'(busy_b), 0);
    endtask

    initial begin
        for (int id = 0; id < 2; id++) begin
            out_cnt[id]  = 0;
            push_cnt[id] = 0;
            done_cnt[id] = 0;
            last_dat[id] = 0;
        end
        repeat (3) @(negedge clk);
        chk_rst();
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, -1, -1);
        run_frame(0, 1'b1, -1, -1);
        run_frame(2, 1'b0, -1, -1);
        run_frame(3, 1'b0, -1, -1);
        run_frame(1, 1'b0, -1, -1);
        run_frame(0, 1'b0, 500, -1);
        run_frame(0, 1'b0, -1, -1);
        run_frame(1, 1'b1, -1, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
